// File: rtl/pipeline_trace_monitor.sv
// pipeline_trace_monitor: MIPS instruction classifier with saturating counters, cycle-limit FSM and PC/class trace FIFO (optional, TRACE_FIFO_EN)
module pipeline_trace_monitor #(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    input  logic [PC_W-1:0]  pc,
    input  logic             trace_rd,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] alu_cnt,
    output logic [CNT_W-1:0] mem_cnt,
    output logic [CNT_W-1:0] ctrl_cnt,
    output logic [CNT_W-1:0] nop_cnt,
    output logic [PC_W-1:0]  trace_pc,
    output logic [2:0]       trace_cls,
    output logic             trace_empty,
    output logic             trace_full,
    output logic             trace_ovf
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t     state, state_nx;
    logic [5:0] op, funct;
    logic [2:0] cls;
    logic       cyc_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign op      = instr[31:26];
    assign funct   = instr[5:0];
    assign running = (state == RUN);
    assign halted  = (state == HALT);
    assign cls = (instr == 32'd0) ? 3'd0 :
                 (op == 6'd0 && (funct inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42})) ? 3'd1 :
                 (op == 6'd0 && funct == 6'd0) ? 3'd2 :
                 (op == 6'd35) ? 3'd3 :
                 (op == 6'd43) ? 3'd4 :
                 (op == 6'd4)  ? 3'd5 :
                 (op == 6'd2)  ? 3'd6 : 3'd7;
    // wide compare so a saturated cycle_cnt can never alias onto a nonzero limit
    assign cyc_hit = (limit != '0) && (({1'b0, cycle_cnt} + (CNT_W+1)'(1)) == {1'b0, limit});

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // next state: clear dominates, HALT is left only through clear
    always_comb begin
        state_nx = state;
        if (clear)                           state_nx = IDLE;
        else if (state == IDLE && start)     state_nx = RUN;
        else if (state == RUN && cyc_hit)    state_nx = HALT;
    end

    // saturating cycle and per-class counters, live only while running
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || clear) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
            alu_cnt   <= '0;
            mem_cnt   <= '0;
            ctrl_cnt  <= '0;
            nop_cnt   <= '0;
        end else if (state == RUN) begin
            cycle_cnt <= sat_inc(cycle_cnt);
            if (instr_valid) begin
                if (cls != 3'd0)                  instr_cnt <= sat_inc(instr_cnt);
                if (cls == 3'd0)                  nop_cnt   <= sat_inc(nop_cnt);
                if (cls == 3'd1 || cls == 3'd2)   alu_cnt   <= sat_inc(alu_cnt);
                if (cls == 3'd3 || cls == 3'd4)   mem_cnt   <= sat_inc(mem_cnt);
                if (cls == 3'd5 || cls == 3'd6)   ctrl_cnt  <= sat_inc(ctrl_cnt);
            end
        end
    end

`ifdef TRACE_FIFO_EN
    localparam int AW = $clog2(TRACE_DEPTH);

    logic [PC_W-1:0] pc_mem  [TRACE_DEPTH];
    logic [2:0]      cls_mem [TRACE_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            wr_req, do_rd, do_wr;

    assign wr_req      = (state == RUN) && instr_valid;
    assign do_rd       = trace_rd && (count != '0);
    assign do_wr       = wr_req && (!trace_full || do_rd);
    assign trace_empty = (count == '0);
    assign trace_full  = (count == (AW+1)'(TRACE_DEPTH));
    assign trace_pc    = trace_empty ? '0 : pc_mem[rd_ptr];
    assign trace_cls   = trace_empty ? 3'd0 : cls_mem[rd_ptr];

    // trace storage, written only on an accepted entry
    always_ff @(posedge clk) begin
        if (do_wr && !clear) begin
            pc_mem[wr_ptr]  <= pc;
            cls_mem[wr_ptr] <= cls;
        end
    end

    // pointers, occupancy and sticky drop flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            trace_ovf <= 1'b0;
        end else begin
            if (do_wr)            wr_ptr    <= wr_ptr + AW'(1);
            if (do_rd)            rd_ptr    <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
            if (wr_req && !do_wr) trace_ovf <= 1'b1;
        end
    end
`else
    logic unused_trace;

    assign unused_trace = ^{trace_rd, pc};
    assign trace_empty  = 1'b1;
    assign trace_full   = 1'b0;
    assign trace_ovf    = 1'b0;
    assign trace_pc     = '0;
    assign trace_cls    = 3'd0;
`endif
endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// tb_pipeline_trace_monitor: spec-level model with per-cycle compare plus directed literal checks
module tb_pipeline_trace_monitor;
`ifdef TRACE_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif
    localparam int     DEPTH = 16;
    localparam longint MAXC  = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, clear = 1'b0, instr_valid = 1'b0, trace_rd = 1'b0;
    logic [31:0] limit = '0, instr = '0, pc = '0;
    logic        running, halted, trace_empty, trace_full, trace_ovf;
    logic [31:0] cycle_cnt, instr_cnt, alu_cnt, mem_cnt, ctrl_cnt, nop_cnt, trace_pc;
    logic [2:0]  trace_cls;

    logic        start_b = 1'b0, clear_b = 1'b0;
    logic [3:0]  limit_b = '0;
    logic        b_running, b_halted, b_empty, b_full, b_ovf;
    logic [3:0]  b_cycle, b_instr, b_alu, b_mem, b_ctrl, b_nop;
    logic [31:0] b_tpc;
    logic [2:0]  b_tcls;

    int n_cmp = 0, n_err = 0;

    pipeline_trace_monitor dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .limit(limit),
        .instr_valid(instr_valid), .instr(instr), .pc(pc), .trace_rd(trace_rd),
        .running(running), .halted(halted), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
        .alu_cnt(alu_cnt), .mem_cnt(mem_cnt), .ctrl_cnt(ctrl_cnt), .nop_cnt(nop_cnt),
        .trace_pc(trace_pc), .trace_cls(trace_cls), .trace_empty(trace_empty),
        .trace_full(trace_full), .trace_ovf(trace_ovf)
    );

    pipeline_trace_monitor #(.CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .clear(clear_b), .limit(limit_b),
        .instr_valid(instr_valid), .instr(instr), .pc(pc), .trace_rd(trace_rd),
        .running(b_running), .halted(b_halted), .cycle_cnt(b_cycle), .instr_cnt(b_instr),
        .alu_cnt(b_alu), .mem_cnt(b_mem), .ctrl_cnt(b_ctrl), .nop_cnt(b_nop),
        .trace_pc(b_tpc), .trace_cls(b_tcls), .trace_empty(b_empty),
        .trace_full(b_full), .trace_ovf(b_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of instance dut ----------------
    int          mode = 0;  // 0 idle, 1 run, 2 halt
    longint      cyc = 0, ic = 0, alu = 0, mem = 0, ctl = 0, nop = 0;
    logic [31:0] qpc[$];
    logic [2:0]  qcls[$];
    bit          ovf = 0;

    function automatic longint sat(input longint v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    function automatic logic [2:0] classify(input logic [31:0] w);
        logic [5:0] f;
        f = w[5:0];
        if (w == 32'd0) return 3'd0;
        case (w[31:26])
            6'd0:    return (f == 6'd32 || f == 6'd34 || f == 6'd36 || f == 6'd37 || f == 6'd42) ? 3'd1 :
                            (f == 6'd0) ? 3'd2 : 3'd7;
            6'd35:   return 3'd3;
            6'd43:   return 3'd4;
            6'd4:    return 3'd5;
            6'd2:    return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    task automatic model_reset();
        mode = 0; cyc = 0; ic = 0; alu = 0; mem = 0; ctl = 0; nop = 0; ovf = 0;
        qpc.delete(); qcls.delete();
    endtask

    always @(posedge clk or negedge rst) begin
        logic [2:0] c;
        if (!rst || clear) model_reset();
        else begin
            if (trace_rd && qpc.size() > 0) begin
                void'(qpc.pop_front());
                void'(qcls.pop_front());
            end
            if (mode == 1) begin
                if (instr_valid) begin
                    c = classify(instr);
                    if (c != 3'd0) ic = sat(ic);
                    if (c == 3'd0) nop = sat(nop);
                    if (c == 3'd1 || c == 3'd2) alu = sat(alu);
                    if (c == 3'd3 || c == 3'd4) mem = sat(mem);
                    if (c == 3'd5 || c == 3'd6) ctl = sat(ctl);
                    if (qpc.size() < DEPTH) begin
                        qpc.push_back(pc);
                        qcls.push_back(c);
                    end else ovf = 1;
                end
                if (limit != 0 && cyc + 1 == longint'(limit)) mode = 2;
                cyc = sat(cyc);
            end else if (mode == 0 && start) mode = 1;
        end
    end

    // per-cycle compare of every dut output against the model
    always @(negedge clk) begin
        logic [31:0] e_pc;
        logic [2:0]  e_cls;
        e_pc  = (FIFO_EN && qpc.size() != 0) ? qpc[0] : 32'd0;
        e_cls = (FIFO_EN && qcls.size() != 0) ? qcls[0] : 3'd0;
        chk("running", 64'(running), 64'(mode == 1));
        chk("halted", 64'(halted), 64'(mode == 2));
        chk("cycle_cnt", 64'(cycle_cnt), cyc);
        chk("instr_cnt", 64'(instr_cnt), ic);
        chk("alu_cnt", 64'(alu_cnt), alu);
        chk("mem_cnt", 64'(mem_cnt), mem);
        chk("ctrl_cnt", 64'(ctrl_cnt), ctl);
        chk("nop_cnt", 64'(nop_cnt), nop);
        chk("trace_pc", 64'(trace_pc), 64'(e_pc));
        chk("trace_cls", 64'(trace_cls), 64'(e_cls));
        chk("trace_empty", 64'(trace_empty), 64'(!FIFO_EN || qpc.size() == 0));
        chk("trace_full", 64'(trace_full), 64'(FIFO_EN && qpc.size() == DEPTH));
        chk("trace_ovf", 64'(trace_ovf), 64'(FIFO_EN && ovf));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    logic [31:0] cls_vec [8] = '{32'h00000000, 32'h012A4020, 32'h00094080, 32'h8FA80004,
                                 32'hAFA80004, 32'h1109FFFF, 32'h08000040, 32'h3C010000};

    initial begin
        #1 rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();

        // reset mid-run
        start = 1'b1; tick(); start = 1'b0;
        instr = 32'h012A4020; instr_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin pc = 32'h80 + 32'(4 * i); tick(); end
        rst = 1'b0;
        #1;
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_cycle", 64'(cycle_cnt), 64'd0);
        chk("rst_alu", 64'(alu_cnt), 64'd0);
        chk("rst_empty", 64'(trace_empty), 64'd1);
        instr_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick(); tick(); tick();
        chk("rst_stay_idle", 64'(running), 64'd0);
        chk("rst_stay_cycle", 64'(cycle_cnt), 64'd0);

        // classification
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            instr = cls_vec[i]; pc = 32'h100 + 32'(4 * i); instr_valid = 1'b1; tick();
        end
        instr_valid = 1'b0; tick();
        chk("cls_nop", 64'(nop_cnt), 64'd1);
        chk("cls_alu", 64'(alu_cnt), 64'd2);
        chk("cls_mem", 64'(mem_cnt), 64'd2);
        chk("cls_ctrl", 64'(ctrl_cnt), 64'd2);
        chk("cls_instr", 64'(instr_cnt), 64'd7);
        chk("cls_head_pc", 64'(trace_pc), FIFO_EN ? 64'h100 : 64'd0);
        do_clear();

        // cycle limit with an lw valid every cycle
        limit = 32'd200; instr = 32'h8FA80004; instr_valid = 1'b1; pc = 32'h4000;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 250; i++) begin pc = pc + 32'd4; tick(); end
        instr_valid = 1'b0;
        chk("lim_cycle", 64'(cycle_cnt), 64'd200);
        chk("lim_halted", 64'(halted), 64'd1);
        chk("lim_mem", 64'(mem_cnt), 64'd200);
        chk("lim_instr", 64'(instr_cnt), 64'd200);
        chk("lim_ovf", 64'(trace_ovf), FIFO_EN ? 64'd1 : 64'd0);
        limit = 32'd0;
        do_clear();
        chk("clr_cycle", 64'(cycle_cnt), 64'd0);
        chk("clr_halted", 64'(halted), 64'd0);
        chk("clr_mem", 64'(mem_cnt), 64'd0);
        chk("clr_ovf", 64'(trace_ovf), 64'd0);

        // limit lowered below cycle_cnt mid-run never halts
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        limit = 32'd5;
        for (int i = 0; i < 20; i++) tick();
        chk("late_lim_halted", 64'(halted), 64'd0);
        chk("late_lim_cycle", 64'(cycle_cnt), 64'd30);
        limit = 32'd0;
        do_clear();

        // FIFO full and overflow
        start = 1'b1; tick(); start = 1'b0;
        instr = 32'h012A4020; instr_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin pc = 32'h1000 + 32'(4 * i); tick(); end
        instr_valid = 1'b0;
        chk("ff_full", 64'(trace_full), FIFO_EN ? 64'd1 : 64'd0);
        chk("ff_ovf", 64'(trace_ovf), FIFO_EN ? 64'd1 : 64'd0);
        chk("ff_head_pc", 64'(trace_pc), FIFO_EN ? 64'h1000 : 64'd0);
        chk("ff_head_cls", 64'(trace_cls), FIFO_EN ? 64'd1 : 64'd0);
        trace_rd = 1'b1; instr_valid = 1'b1; pc = 32'h2FFC; tick();
        trace_rd = 1'b0; instr_valid = 1'b0;
        chk("ff_rw_full", 64'(trace_full), FIFO_EN ? 64'd1 : 64'd0);
        chk("ff_rw_ovf", 64'(trace_ovf), FIFO_EN ? 64'd1 : 64'd0);
        chk("ff_rw_head", 64'(trace_pc), FIFO_EN ? 64'h1004 : 64'd0);
        do_clear();

        // streaming through pointer wrap, then reads past empty
        start = 1'b1; tick(); start = 1'b0;
        instr = 32'h08000040;
        for (int i = 0; i < 40; i++) begin
            instr_valid = 1'b1; pc = 32'h2000 + 32'(4 * i); trace_rd = (i >= 2);
            if (i >= 2) chk("wrap_pc", 64'(trace_pc), FIFO_EN ? 64'(32'h2000 + 32'(4 * (i - 2))) : 64'd0);
            tick();
        end
        instr_valid = 1'b0; trace_rd = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        trace_rd = 1'b0;
        chk("drain_empty", 64'(trace_empty), 64'd1);
        chk("drain_pc", 64'(trace_pc), 64'd0);
        do_clear();

        // saturation on the 4-bit instance
        start_b = 1'b1; instr = 32'h012A4020; instr_valid = 1'b1; tick(); start_b = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        instr_valid = 1'b0; tick();
        chk("sat_alu", 64'(b_alu), 64'd15);
        chk("sat_instr", 64'(b_instr), 64'd15);
        chk("sat_cycle", 64'(b_cycle), 64'd15);
        chk("sat_halted", 64'(b_halted), 64'd0);
        chk("sat_running", 64'(b_running), 64'd1);
        clear_b = 1'b1; tick(); clear_b = 1'b0;
        chk("sat_clear", 64'(b_alu), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
